// File: rtl/bird_collision_scorer.sv
// Collision detection, scoring, lives tracking and game-state sequencing for
// the bird game. The block consumes the one-hot bird row and the pipe pixels
// in the bird's display column, and it returns a die pulse to the bird
// movement block whenever a hit is detected.
module bird_collision_scorer #(
    parameter int unsigned SCORE_W     = 8,
    parameter int unsigned LIVES       = 3,
    parameter int unsigned GRACE_TICKS = 2
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               restart_i,
    input  logic [15:0]        bird_i,
    input  logic [15:0]        pipe_col_i,
    input  logic               col_tick_i,
    output logic               die_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [1:0]         lives_left_o,
    output logic               game_over_o
);

    localparam int unsigned COL_W   = 16;
    localparam int unsigned LIVES_W = 2;
    localparam int unsigned GRACE_W = (GRACE_TICKS < 1) ? 1 : $clog2(GRACE_TICKS + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_PAUSE = 3'd2,
        ST_HIT   = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [COL_W-1:0]   cur_col_q, cur_col_d;
    logic [GRACE_W-1:0] grace_q, grace_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic               die_q, die_d;
    logic               game_over_q, game_over_d;

    logic               hit_c;
    logic               pipe_cleared_c;
    logic               score_sat_c;

    // Hit: bird overlaps the latched pipe column or fell off the display; masked during grace.
    assign hit_c = (grace_q == '0) &&
                   (((bird_i & cur_col_q) != '0) || (bird_i == '0));

    // A pipe is cleared when the column goes from occupied to fully empty.
    assign pipe_cleared_c = (cur_col_q != '0) && (pipe_col_i == '0);

    assign score_sat_c = &score_q;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            cur_col_q   <= '0;
            grace_q     <= '0;
            score_q     <= '0;
            lives_q     <= LIVES_W'(LIVES);
            die_q       <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_col_q   <= cur_col_d;
            grace_q     <= grace_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            die_q       <= die_d;
            game_over_q <= game_over_d;
        end
    end

    // Next-state, datapath update and registered-output decode.
    always_comb begin
        state_d     = state_q;
        cur_col_d   = cur_col_q;
        grace_d     = grace_q;
        score_d     = score_q;
        lives_d     = lives_q;
        die_d       = 1'b0;
        game_over_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_PLAY;
                end
            end

            ST_PLAY: begin
                if (!start_i) begin
                    // Pausing wins over everything else in the same cycle.
                    state_d = ST_PAUSE;
                end else begin
                    if (col_tick_i) begin
                        cur_col_d = pipe_col_i;
                    end
                    if (hit_c) begin
                        // Hit suppresses any score increment on a coincident tick.
                        state_d = ST_HIT;
                        die_d   = 1'b1;
                        lives_d = lives_q - LIVES_W'(1);
                    end else if (col_tick_i) begin
                        if (grace_q != '0) begin
                            grace_d = grace_q - GRACE_W'(1);
                        end
                        if (pipe_cleared_c && !score_sat_c) begin
                            score_d = score_q + SCORE_W'(1);
                        end
                    end
                end
            end

            ST_PAUSE: begin
                if (start_i) begin
                    state_d = ST_PLAY;
                end
            end

            ST_HIT: begin
                // lives_q already holds the decremented count here.
                if (lives_q == '0) begin
                    state_d     = ST_OVER;
                    game_over_d = 1'b1;
                end else begin
                    state_d = ST_PLAY;
                    grace_d = GRACE_W'(GRACE_TICKS);
                end
            end

            ST_OVER: begin
                if (restart_i) begin
                    state_d   = ST_IDLE;
                    score_d   = '0;
                    lives_d   = LIVES_W'(LIVES);
                    cur_col_d = '0;
                    grace_d   = '0;
                end else begin
                    game_over_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign die_o        = die_q;
    assign score_o      = score_q;
    assign lives_left_o = lives_q;
    assign game_over_o  = game_over_q;

endmodule

// File: tb/tb_bird_collision_scorer.sv
// Directed bench for bird_collision_scorer: a table of per-cycle vectors
// followed by hand-written sequences for saturation and reset corner cases.
module tb_bird_collision_scorer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        restart;
    logic [15:0] bird;
    logic [15:0] pipe_col;
    logic        col_tick;
    logic        die;
    logic [7:0]  score;
    logic [1:0]  lives_left;
    logic        game_over;

    int total = 0;
    int bad   = 0;

    bird_collision_scorer #(
        .SCORE_W    (8),
        .LIVES      (3),
        .GRACE_TICKS(2)
    ) dut (
        .clock_i     (clk),
        .reset_i     (rst),
        .start_i     (start),
        .restart_i   (restart),
        .bird_i      (bird),
        .pipe_col_i  (pipe_col),
        .col_tick_i  (col_tick),
        .die_o       (die),
        .score_o     (score),
        .lives_left_o(lives_left),
        .game_over_o (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        start;
        logic        restart;
        logic        tick;
        logic [15:0] bird;
        logic [15:0] pipe;
        logic        die;
        logic [7:0]  score;
        logic [1:0]  lives;
        logic        go;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic s, input logic rs, input logic t,
                                input logic [15:0] b, input logic [15:0] p,
                                input logic d, input logic [7:0] sc, input logic [1:0] l,
                                input logic g);
        vec_t v;
        v.rst = r; v.start = s; v.restart = rs; v.tick = t;
        v.bird = b; v.pipe = p;
        v.die = d; v.score = sc; v.lives = l; v.go = g;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the active edge.
    task automatic cyc(input logic r, input logic s, input logic rs, input logic t,
                       input logic [15:0] b, input logic [15:0] p);
        @(negedge clk);
        rst = r; start = s; restart = rs; col_tick = t; bird = b; pipe_col = p;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic d, input logic [7:0] sc,
                           input logic [1:0] l, input logic g);
        chk({tag, ".die"}, 32'(die), 32'(d));
        chk({tag, ".score"}, 32'(score), 32'(sc));
        chk({tag, ".lives"}, 32'(lives_left), 32'(l));
        chk({tag, ".game_over"}, 32'(game_over), 32'(g));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; restart = 1'b0; col_tick = 1'b0;
        bird = 16'h0100; pipe_col = 16'h0000;

        //                rst  st  rs  tk  bird      pipe       die sc    lv  go
        vecs[0]  = mk(1, 0, 0, 0, 16'h0100, 16'h0000, 0, 8'd0, 2'd3, 0); // reset
        vecs[1]  = mk(0, 1, 0, 0, 16'h0100, 16'h0000, 0, 8'd0, 2'd3, 0); // IDLE->PLAY
        vecs[2]  = mk(0, 1, 0, 1, 16'h0100, 16'hF00F, 0, 8'd0, 2'd3, 0); // no overlap
        vecs[3]  = mk(0, 1, 0, 1, 16'h0100, 16'h0000, 0, 8'd1, 2'd3, 0); // pipe cleared
        vecs[4]  = mk(0, 1, 0, 1, 16'h0100, 16'h0100, 0, 8'd1, 2'd3, 0); // load overlap col
        vecs[5]  = mk(0, 1, 0, 0, 16'h0100, 16'h0000, 1, 8'd1, 2'd2, 0); // hit -> die
        vecs[6]  = mk(0, 1, 0, 0, 16'h0100, 16'h0000, 0, 8'd1, 2'd2, 0); // die one cycle
        vecs[7]  = mk(0, 1, 0, 0, 16'h0100, 16'h0000, 0, 8'd1, 2'd2, 0); // grace 2
        vecs[8]  = mk(0, 1, 0, 1, 16'h0100, 16'h0100, 0, 8'd1, 2'd2, 0); // grace ->1
        vecs[9]  = mk(0, 1, 0, 0, 16'h0100, 16'h0000, 0, 8'd1, 2'd2, 0); // still grace
        vecs[10] = mk(0, 1, 0, 1, 16'h0100, 16'h0100, 0, 8'd1, 2'd2, 0); // grace ->0
        vecs[11] = mk(0, 1, 0, 0, 16'h0100, 16'h0000, 1, 8'd1, 2'd1, 0); // second hit
        vecs[12] = mk(0, 1, 0, 0, 16'h0100, 16'h0000, 0, 8'd1, 2'd1, 0); // HIT->PLAY
        vecs[13] = mk(0, 1, 0, 1, 16'h0100, 16'h0000, 0, 8'd2, 2'd1, 0); // score in grace
        vecs[14] = mk(0, 1, 0, 1, 16'h0100, 16'h0000, 0, 8'd2, 2'd1, 0); // empty->empty
        vecs[15] = mk(0, 1, 0, 0, 16'h0000, 16'h0000, 1, 8'd2, 2'd0, 0); // fell off: hit
        vecs[16] = mk(0, 1, 0, 0, 16'h0100, 16'h0000, 0, 8'd2, 2'd0, 1); // OVER
        vecs[17] = mk(0, 1, 0, 1, 16'h0100, 16'hFFFF, 0, 8'd2, 2'd0, 1); // ticks ignored
        vecs[18] = mk(0, 1, 1, 0, 16'h0100, 16'h0000, 0, 8'd0, 2'd3, 0); // restart->IDLE
        vecs[19] = mk(0, 1, 0, 0, 16'h0100, 16'h0000, 0, 8'd0, 2'd3, 0); // IDLE->PLAY
        vecs[20] = mk(0, 1, 0, 1, 16'h0100, 16'h00F0, 0, 8'd0, 2'd3, 0);
        vecs[21] = mk(0, 1, 0, 1, 16'h0100, 16'h0000, 0, 8'd1, 2'd3, 0); // score 1
        vecs[22] = mk(0, 1, 1, 0, 16'h0100, 16'h0000, 0, 8'd1, 2'd3, 0); // restart ignored
        vecs[23] = mk(0, 1, 0, 1, 16'h0100, 16'h0100, 0, 8'd1, 2'd3, 0); // load overlap col
        vecs[24] = mk(0, 0, 0, 0, 16'h0100, 16'h0000, 0, 8'd1, 2'd3, 0); // pause beats hit
        vecs[25] = mk(0, 0, 0, 1, 16'h0100, 16'h0000, 0, 8'd1, 2'd3, 0); // tick in PAUSE
        vecs[26] = mk(0, 1, 0, 0, 16'h0100, 16'h0000, 0, 8'd1, 2'd3, 0); // PAUSE->PLAY
        vecs[27] = mk(0, 1, 0, 1, 16'h0100, 16'h0000, 1, 8'd1, 2'd2, 0); // hit beats score
        vecs[28] = mk(0, 1, 0, 0, 16'h0100, 16'h0000, 0, 8'd1, 2'd2, 0); // HIT->PLAY

        for (int i = 0; i < NV; i++) begin
            cyc(vecs[i].rst, vecs[i].start, vecs[i].restart, vecs[i].tick,
                vecs[i].bird, vecs[i].pipe);
            chk_out($sformatf("vec%0d", i), vecs[i].die, vecs[i].score,
                    vecs[i].lives, vecs[i].go);
        end

        // Score saturation, then reset from PAUSE.
        cyc(1, 0, 0, 0, 16'h0100, 16'h0000);
        cyc(0, 1, 0, 0, 16'h0100, 16'h0000);
        for (int i = 0; i < 258; i++) begin
            cyc(0, 1, 0, 1, 16'h0100, 16'hF00F);
            cyc(0, 1, 0, 1, 16'h0100, 16'h0000);
            if (i == 9) chk("score_after_10", 32'(score), 32'd10);
        end
        chk_out("sat", 1'b0, 8'hFF, 2'd3, 1'b0);
        cyc(0, 0, 0, 0, 16'h0100, 16'h0000);
        cyc(0, 0, 0, 1, 16'h0100, 16'hF00F);
        chk("pause_score", 32'(score), 32'hFF);
        cyc(1, 0, 0, 0, 16'h0100, 16'h0000);
        chk_out("rst_pause", 1'b0, 8'd0, 2'd3, 1'b0);

        // Reset asserted while in HIT: no die pulse afterwards.
        cyc(0, 1, 0, 0, 16'h0100, 16'h0000);
        cyc(0, 1, 0, 1, 16'h0100, 16'h0100);
        cyc(0, 1, 0, 0, 16'h0100, 16'h0000);
        chk_out("enter_hit", 1'b1, 8'd0, 2'd2, 1'b0);
        cyc(1, 1, 0, 0, 16'h0100, 16'h0000);
        chk_out("rst_hit", 1'b0, 8'd0, 2'd3, 1'b0);
        cyc(0, 0, 0, 0, 16'h0100, 16'h0000);
        chk_out("after_rst_hit", 1'b0, 8'd0, 2'd3, 1'b0);

        // Three hits from a fallen bird lead to OVER; then reset from OVER.
        cyc(0, 1, 0, 0, 16'h0000, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 0, 0, 16'h0000, 16'h0000);
            chk($sformatf("over_die%0d", k), 32'(die), 32'd1);
            chk($sformatf("over_lives%0d", k), 32'(lives_left), 32'(2 - k));
            cyc(0, 1, 0, 0, 16'h0000, 16'h0000);
            if (k < 2) begin
                chk($sformatf("over_nodie%0d", k), 32'(die), 32'd0);
                cyc(0, 1, 0, 1, 16'h0000, 16'h0000);
                cyc(0, 1, 0, 1, 16'h0000, 16'h0000);
            end
        end
        chk_out("over", 1'b0, 8'd0, 2'd0, 1'b1);
        cyc(1, 1, 0, 0, 16'h0000, 16'h0000);
        chk_out("rst_over", 1'b0, 8'd0, 2'd3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
